// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core: hazard FSM states,
// register-index width and the NOP/bubble encodings used by the stall mux.
package riscv_pipe_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Stall mux select encodings and the instruction a flushed register holds.
    localparam logic        PASS_SEL   = 1'b1;
    localparam logic        BUBBLE_SEL = 1'b0;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use interlock, taken-branch flush and a timed
// data-memory wait FSM, with saturating stall/flush event counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IFID_rs1,
    input  logic [REG_W-1:0] IFID_rs2,
    input  logic             IFID_uses_rs2,
    input  logic             IDEX_Mem_rd,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             Mux_stall_sel,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]  BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [15:0] TIMEOUT  = 16'(MEM_TIMEOUT);

    hz_state_t   state, state_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic [1:0]  bub_cnt, bub_nxt;
    logic        luh, mem_stall, decode;

    assign luh = IDEX_Mem_rd && (IDEX_rd != '0) &&
                 ((IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));
    assign mem_stall = dmem_req && !dmem_ready;

    // Outputs are Mealy so the PC never advances past a hazard; decode marks the
    // cycles where the ordinary branch/load-use priority applies, including release.
    always_comb begin
        Mux_stall_sel = PASS_SEL;
        PC_write      = 1'b1;
        IFID_write    = 1'b1;
        IFID_flush    = 1'b0;
        IDEX_flush    = 1'b0;
        pipe_hold     = 1'b0;
        mem_err       = 1'b0;
        decode        = 1'b0;
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        bub_nxt       = bub_cnt;

        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    pipe_hold  = 1'b1;
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = 16'd1;
                end else begin
                    decode = 1'b1;
                end
            end
            LU_STALL: begin
                if (mem_stall) begin
                    pipe_hold  = 1'b1;
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = 16'd1;
                end else begin
                    Mux_stall_sel = BUBBLE_SEL;
                    PC_write      = 1'b0;
                    IFID_write    = 1'b0;
                    if (bub_cnt == 2'd1) state_nxt = RUN;
                    else                 bub_nxt   = bub_cnt - 2'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    decode    = 1'b1;
                    state_nxt = RUN;
                end else if (wait_cnt == TIMEOUT) begin
                    mem_err   = 1'b1;
                    decode    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    pipe_hold  = 1'b1;
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    wait_nxt   = wait_cnt + 16'd1;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (decode) begin
            if (branch_taken) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
                PC_write   = 1'b1;
            end else if (luh) begin
                Mux_stall_sel = BUBBLE_SEL;
                PC_write      = 1'b0;
                IFID_write    = 1'b0;
                if (LOAD_USE_BUBBLES > 1) begin
                    state_nxt = LU_STALL;
                    bub_nxt   = BUB_INIT;
                end
            end
        end

        if (!rst_n) begin
            Mux_stall_sel = PASS_SEL;
            PC_write      = 1'b1;
            IFID_write    = 1'b1;
            IFID_flush    = 1'b0;
            IDEX_flush    = 1'b0;
            pipe_hold     = 1'b0;
            mem_err       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            bub_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            bub_cnt  <= bub_nxt;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((Mux_stall_sel == BUBBLE_SEL) || pipe_hold),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (IFID_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: two instances (1 bubble / timeout 8 /
// 4-bit counters, and 3 bubbles / timeout 255 / 16-bit counters) share stimulus.
module tb_hazard_ctrl;

    // Expected output vector order: {sel, pc_w, ifid_w, ifid_fl, idex_fl, hold, err}
    localparam logic [6:0] NORM = 7'b111_0000;
    localparam logic [6:0] LU   = 7'b000_0000;
    localparam logic [6:0] BR   = 7'b111_1100;
    localparam logic [6:0] HOLD = 7'b100_0010;
    localparam logic [6:0] ERR  = 7'b111_0001;

    typedef struct {
        string      tag;
        logic [6:0] e1;
        logic [6:0] e3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IFID_rs1, IFID_rs2, IDEX_rd;
    logic        IFID_uses_rs2, IDEX_Mem_rd, branch_taken, dmem_req, dmem_ready;

    logic        sel1, pcw1, ifw1, iff1, idf1, hold1, err1;
    logic [3:0]  scnt1, fcnt1;
    logic        sel3, pcw3, ifw3, iff3, idf3, hold3, err3;
    logic [15:0] scnt3, fcnt3;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_uses_rs2(IFID_uses_rs2), .IDEX_Mem_rd(IDEX_Mem_rd), .IDEX_rd(IDEX_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .Mux_stall_sel(sel1), .PC_write(pcw1), .IFID_write(ifw1), .IFID_flush(iff1),
        .IDEX_flush(idf1), .pipe_hold(hold1), .mem_err(err1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_uses_rs2(IFID_uses_rs2), .IDEX_Mem_rd(IDEX_Mem_rd), .IDEX_rd(IDEX_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .Mux_stall_sel(sel3), .PC_write(pcw3), .IFID_write(ifw3), .IFID_flush(iff3),
        .IDEX_flush(idf3), .pipe_hold(hold3), .mem_err(err3),
        .stall_cnt(scnt3), .flush_cnt(fcnt3)
    );

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic memrd, input logic [4:0] rd, input logic br,
                         input logic req, input logic rdy);
        IFID_rs1 = rs1; IFID_rs2 = rs2; IFID_uses_rs2 = uses;
        IDEX_Mem_rd = memrd; IDEX_rd = rd; branch_taken = br;
        dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation, compare both instances at the falling edge, then
    // advance past the next rising edge.
    task automatic step(input string tag, input logic [6:0] e1, input logic [6:0] e3);
        exp_t e, x;
        logic [6:0] o1, o3;
        e.tag = tag; e.e1 = e1; e.e3 = e3;
        sb.push_back(e);
        @(negedge clk);
        x  = sb.pop_front();
        o1 = {sel1, pcw1, ifw1, iff1, idf1, hold1, err1};
        o3 = {sel3, pcw3, ifw3, iff3, idf3, hold3, err3};
        checks++;
        assert (o1 === x.e1) else begin
            failures++;
            $error("FAIL %s/u1 got=%b exp=%b", x.tag, o1, x.e1);
        end
        checks++;
        assert (o3 === x.e3) else begin
            failures++;
            $error("FAIL %s/u3 got=%b exp=%b", x.tag, o3, x.e3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every hazard input active: outputs must stay at reset values.
        rst_n = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        step("reset", NORM, NORM);
        chk_cnt("rst_scnt1", 16'(scnt1), 16'd0);
        chk_cnt("rst_scnt3", scnt3, 16'd0);
        rst_n = 1'b1;
        idle();
        step("idle", NORM, NORM);

        // Load x5 in EX, ID reads rs1=x5.
        drive(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", LU, LU);
        idle();
        step("lu_rs1_b2", NORM, LU);
        step("lu_rs1_b3", NORM, LU);
        step("lu_rs1_end", NORM, NORM);
        chk_cnt("lu_scnt1", 16'(scnt1), 16'd1);
        chk_cnt("lu_scnt3", scnt3, 16'd3);

        // Load into x0 never interlocks.
        drive(5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("lu_x0", NORM, NORM);

        // rs2 match only counts when rs2 is used.
        drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step("rs2_unused", NORM, NORM);
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step("rs2_used", LU, LU);
        idle();
        step("rs2_b2", NORM, LU);
        step("rs2_b3", NORM, LU);
        step("rs2_end", NORM, NORM);
        chk_cnt("rs2_scnt1", 16'(scnt1), 16'd2);
        chk_cnt("rs2_scnt3", scnt3, 16'd6);

        // Branch wins over a simultaneous load-use hazard.
        drive(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("br_luh", BR, BR);
        idle();
        step("br_after", NORM, NORM);
        chk_cnt("br_fcnt1", 16'(fcnt1), 16'd1);
        chk_cnt("br_fcnt3", fcnt3, 16'd1);

        // Four wait cycles; a branch seen during the hold acts only on release.
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("wait1", HOLD, HOLD);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step("wait2_br", HOLD, HOLD);
        step("wait3_br", HOLD, HOLD);
        step("wait4_br", HOLD, HOLD);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        step("wait_rel_br", BR, BR);
        idle();
        step("wait_after", NORM, NORM);
        chk_cnt("wait_scnt1", 16'(scnt1), 16'd6);
        chk_cnt("wait_scnt3", scnt3, 16'd10);
        chk_cnt("wait_fcnt1", 16'(fcnt1), 16'd2);
        chk_cnt("wait_fcnt3", fcnt3, 16'd2);

        // Ready never rises: u1 (timeout 8) holds 8 cycles then flags mem_err.
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step($sformatf("to_hold%0d", i), HOLD, HOLD);
        step("to_err", ERR, HOLD);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("to_after", NORM, HOLD);

        // Reset while u3 is still waiting.
        rst_n = 1'b0;
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("rst_wait", NORM, NORM);
        chk_cnt("rst2_scnt1", 16'(scnt1), 16'd0);
        chk_cnt("rst2_fcnt3", fcnt3, 16'd0);
        rst_n = 1'b1;
        idle();
        step("rst_run", NORM, NORM);

        // 20 consecutive stall cycles: the 4-bit counter saturates at 15.
        drive(5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), LU, LU);
        chk_cnt("sat_scnt1", 16'(scnt1), 16'd15);
        chk_cnt("sat_scnt3", scnt3, 16'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
